// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter and sequencer sharing one UART transmitter among
//   N_REQ byte-producing clients. The transmitter reports neither busy nor
//   done, so the block reserves a fixed FRAME_CYCLES window per byte.
//   Within that window it drives tx_data/tx_send. At the end of the window
//   it pulses ack to the client that was served.
//
// Ports
//   clk       : single clock for all state
//   nrst      : asynchronous, active-low reset
//   req       : level request per client, held until acknowledged
//   req_data  : client i byte on bits [8i+7:8i]
//   ack       : one-cycle pulse to the served client
//   grant_id  : index of the client currently / last served
//   busy      : high from grant through ack
//   tx_data   : byte driven to the transmitter
//   tx_send   : send strobe, PULSE_CYCLES clocks wide
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int FRAME_CYCLES = 57288,
  parameter int PULSE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [N_REQ-1:0]         req,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         ack,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic [7:0]               tx_data,
  output logic                     tx_send
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(FRAME_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [IDW-1:0]   last_reg;
  logic [IDW-1:0]   grant_reg;
  logic [7:0]       data_reg;
  logic [N_REQ-1:0] ack_reg;
  logic             busy_reg;
  logic             send_reg;

  logic             win_valid;
  logic [IDW-1:0]   win_id;
  logic [7:0]       win_byte;
  logic [N_REQ-1:0] grant_onehot;

  // Round-robin search starting at last+1. The loop walks from the farthest
  // offset down to the nearest, so the nearest requesting client wins.
  always_comb begin
    int idx;
    win_valid = 1'b0;
    win_id    = '0;
    win_byte  = 8'h00;
    idx       = 0;
    for (int off = N_REQ; off >= 1; off--) begin
      idx = (int'(last_reg) + off) % N_REQ;
      if (req[idx]) begin
        win_valid = 1'b1;
        win_id    = IDW'(idx);
        win_byte  = req_data[idx*8 +: 8];
      end
    end
  end

  assign grant_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << grant_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      last_reg  <= IDW'(N_REQ - 1);
      grant_reg <= '0;
      data_reg  <= 8'h00;
      ack_reg   <= '0;
      busy_reg  <= 1'b0;
      send_reg  <= 1'b0;
    end else begin
      ack_reg <= '0;
      case (state_reg)
        // The DONE cycle is the last cycle of the frame. The edge that
        // leaves DONE is also the first IDLE arbitration. That keeps the
        // frame pitch at FRAME_CYCLES+1 when requests are back-to-back.
        S_IDLE, S_DONE: begin
          if (win_valid) begin
            state_reg <= S_SEND;
            cnt_reg   <= '0;
            last_reg  <= win_id;
            grant_reg <= win_id;
            data_reg  <= win_byte;
            busy_reg  <= 1'b1;
            send_reg  <= 1'b1;
          end else begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        S_SEND: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(PULSE_CYCLES - 1)) begin
            send_reg  <= 1'b0;
            state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_reg == CW'(FRAME_CYCLES - 1)) begin
            state_reg <= S_DONE;
            ack_reg   <= grant_onehot;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign ack      = ack_reg;
  assign grant_id = grant_reg;
  assign busy     = busy_reg;
  assign tx_data  = data_reg;
  assign tx_send  = send_reg;

endmodule
